minterm_sweep_checker: RTL and testbench

- Reads the truth table of a combinational logic function under test (4-variable K-map style, inputs x,y,w,z) by sweeping every input combination in order and sampling the function's 1-bit output.
- Rebuilds the function's minterm mask and compares it against an expected ∑m mask.
- Serves as the self-checking reader for the team's simplified-function modules, replacing hand-read $monitor tables.

---
 rtl/minterm_sweep_checker_pkg.sv | 15 +
 rtl/minterm_sweep_checker.sv | 119 +++++++++++
 tb/tb_minterm_sweep_checker.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/minterm_sweep_checker_pkg.sv
// Shared types and limits for the minterm sweep checker.
// The state encoding is shared so benches and wrappers can decode it.
package minterm_sweep_checker_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_e;

  localparam int MAX_VARS   = 6;
  localparam int MAX_SETTLE = 15;

endpackage

// File: rtl/minterm_sweep_checker.sv
// Sweeps every input vector of a combinational function, rebuilds its minterm
// mask and compares it against a latched expected mask.
module minterm_sweep_checker
  import minterm_sweep_checker_pkg::*;
#(
  parameter int N_VARS = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [2**N_VARS-1:0]   expected,
  output logic [N_VARS-1:0]      drive,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [2**N_VARS-1:0]   captured,
  output logic                   match,
  output logic [N_VARS:0]        mismatch_count,
  output logic [N_VARS-1:0]      first_bad,
  output logic                   first_bad_valid
);

  localparam int                TBL       = 2**N_VARS;
  localparam logic [3:0]        SETTLE_LD = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
  localparam logic [N_VARS-1:0] LAST      = {N_VARS{1'b1}};
  // With no settle time every window is a single SAMPLE cycle.
  localparam state_e            WIN_ST    = (SETTLE == 0) ? SAMPLE : WAIT;

  state_e              state_q;
  logic [N_VARS-1:0]   idx_q;
  logic [3:0]          settle_q;
  logic [TBL-1:0]      expected_q;
  logic [TBL-1:0]      captured_q;
  logic [N_VARS:0]     mcnt_q;
  logic [N_VARS:0]     mcnt_d;
  logic [N_VARS-1:0]   first_bad_q;
  logic                fbv_q;
  logic                match_q;
  logic                busy_q;
  logic                done_q;
  logic                bad_d;

  always_comb begin
    bad_d  = f_in ^ expected_q[idx_q];
    mcnt_d = mcnt_q + {{N_VARS{1'b0}}, bad_d};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      settle_q    <= '0;
      expected_q  <= '0;
      captured_q  <= '0;
      mcnt_q      <= '0;
      first_bad_q <= '0;
      fbv_q       <= 1'b0;
      match_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= WIN_ST;
            idx_q       <= '0;
            settle_q    <= SETTLE_LD;
            expected_q  <= expected;
            busy_q      <= 1'b1;
            captured_q  <= '0;
            mcnt_q      <= '0;
            first_bad_q <= '0;
            fbv_q       <= 1'b0;
            match_q     <= 1'b0;
          end
        end
        WAIT: begin
          if (settle_q == 4'd0) state_q  <= SAMPLE;
          else                  settle_q <= settle_q - 4'd1;
        end
        SAMPLE: begin
          captured_q[idx_q] <= f_in;
          mcnt_q            <= mcnt_d;
          if (bad_d && !fbv_q) begin
            first_bad_q <= idx_q;
            fbv_q       <= 1'b1;
          end
          // Final index ends the sweep; idx never wraps back to zero here.
          if (idx_q == LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            match_q <= (mcnt_d == '0);
          end else begin
            idx_q    <= idx_q + 1'b1;
            settle_q <= SETTLE_LD;
            state_q  <= WIN_ST;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign drive           = idx_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign captured        = captured_q;
  assign match           = match_q;
  assign mismatch_count  = mcnt_q;
  assign first_bad       = first_bad_q;
  assign first_bad_valid = fbv_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Bench for minterm_sweep_checker: three builds (SETTLE=1, 0, 3), each driven by
// a truth-table model of the function under test, results checked via a scoreboard.
module tb_minterm_sweep_checker;

  typedef struct {
    logic [15:0] cap;
    logic [4:0]  cnt;
    logic [3:0]  fb;
    logic        fbv;
    logic        m;
    int          lat;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [2:0]        start_v;
  logic [2:0][15:0]  exp_v;
  logic [2:0][15:0]  model_v;
  logic [2:0][15:0]  cap_v;
  logic [2:0][3:0]   drive_v;
  logic [2:0][3:0]   fb_v;
  logic [2:0][4:0]   cnt_v;
  logic [2:0]        f_v, busy_v, done_v, match_v, fbv_v;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int settle_of[3] = '{1, 0, 3};

  always @(posedge clk) cyc <= cyc + 1;

  assign f_v[0] = model_v[0][drive_v[0]];
  assign f_v[1] = model_v[1][drive_v[1]];
  assign f_v[2] = model_v[2][drive_v[2]];

  minterm_sweep_checker #(.N_VARS(4), .SETTLE(1)) u_s1 (
    .clk(clk), .reset(reset), .start(start_v[0]), .expected(exp_v[0]),
    .drive(drive_v[0]), .f_in(f_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .captured(cap_v[0]), .match(match_v[0]), .mismatch_count(cnt_v[0]),
    .first_bad(fb_v[0]), .first_bad_valid(fbv_v[0]));

  minterm_sweep_checker #(.N_VARS(4), .SETTLE(0)) u_s0 (
    .clk(clk), .reset(reset), .start(start_v[1]), .expected(exp_v[1]),
    .drive(drive_v[1]), .f_in(f_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .captured(cap_v[1]), .match(match_v[1]), .mismatch_count(cnt_v[1]),
    .first_bad(fb_v[1]), .first_bad_valid(fbv_v[1]));

  minterm_sweep_checker #(.N_VARS(4), .SETTLE(3)) u_s3 (
    .clk(clk), .reset(reset), .start(start_v[2]), .expected(exp_v[2]),
    .drive(drive_v[2]), .f_in(f_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .captured(cap_v[2]), .match(match_v[2]), .mismatch_count(cnt_v[2]),
    .first_bad(fb_v[2]), .first_bad_valid(fbv_v[2]));

  function automatic exp_t predict(input logic [15:0] e, input logic [15:0] m, input int settle);
    exp_t r;
    r.cap = m;
    r.cnt = '0;
    r.fb  = '0;
    r.fbv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (m[i] !== e[i]) begin
        r.cnt = r.cnt + 5'd1;
        if (!r.fbv) begin
          r.fb  = i[3:0];
          r.fbv = 1'b1;
        end
      end
    end
    r.m   = (r.cnt == 5'd0);
    r.lat = 1 + 16 * (settle + 1);
    return r;
  endfunction

  task automatic do_start(input int u, input logic [15:0] e, input bit at_neg, output int k);
    if (!at_neg) @(negedge clk);
    exp_v[u]   = e;
    start_v[u] = 1'b1;
    @(posedge clk);
    #1;
    k          = cyc;
    start_v[u] = 1'b0;
    vectors++;
    if (busy_v[u] !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start u%0d: got %b want 1", u, busy_v[u]);
    end
  endtask

  task automatic wait_check(input int u, input int k, input string name);
    exp_t x;
    bit   got = 0;
    int   lat;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (done_v[u] === 1'b1) got = 1;
    end
    x = sb.pop_front();
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s done_timeout: no done pulse within 300 cycles", name);
      return;
    end
    lat = cyc - k + 1;
    vectors++;
    if (lat != x.lat) begin
      miscompares++;
      $display("FAIL %s latency: got k+%0d want k+%0d", name, lat, x.lat);
    end
    vectors++;
    if (cap_v[u] !== x.cap) begin
      miscompares++;
      $display("FAIL %s captured: got %h want %h", name, cap_v[u], x.cap);
    end
    vectors++;
    if (cnt_v[u] !== x.cnt) begin
      miscompares++;
      $display("FAIL %s mismatch_count: got %0d want %0d", name, cnt_v[u], x.cnt);
    end
    vectors++;
    if (fbv_v[u] !== x.fbv || fb_v[u] !== x.fb) begin
      miscompares++;
      $display("FAIL %s first_bad: got v=%b idx=%0d want v=%b idx=%0d",
               name, fbv_v[u], fb_v[u], x.fbv, x.fb);
    end
    vectors++;
    if (match_v[u] !== x.m || busy_v[u] !== 1'b0) begin
      miscompares++;
      $display("FAIL %s match_busy: got match=%b busy=%b want match=%b busy=0",
               name, match_v[u], busy_v[u], x.m);
    end
    @(negedge clk);
    vectors++;
    if (done_v[u] !== 1'b0 || drive_v[u] !== 4'hF || cap_v[u] !== x.cap) begin
      miscompares++;
      $display("FAIL %s idle_hold: got done=%b drive=%h cap=%h want done=0 drive=f cap=%h",
               name, done_v[u], drive_v[u], cap_v[u], x.cap);
    end
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    start_v = '0;
    exp_v   = '0;
    model_v = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      vectors++;
      if ({busy_v[u], done_v[u], match_v[u], fbv_v[u], drive_v[u], fb_v[u], cnt_v[u], cap_v[u]} !== '0) begin
        miscompares++;
        $display("FAIL reset_state u%0d: got busy=%b done=%b match=%b fbv=%b drive=%h fb=%h cnt=%0d cap=%h want all 0",
                 u, busy_v[u], done_v[u], match_v[u], fbv_v[u], drive_v[u], fb_v[u], cnt_v[u], cap_v[u]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_exact(input int u, input string name);
    int k;
    model_v[u] = 16'h88CA;
    sb.push_back(predict(16'h88CA, model_v[u], settle_of[u]));
    do_start(u, 16'h88CA, 0, k);
    wait_check(u, k, name);
  endtask

  task automatic test_single_fault();
    int k;
    model_v[0] = 16'h88CA & ~16'h0040;
    sb.push_back(predict(16'h88CA, model_v[0], settle_of[0]));
    do_start(0, 16'h88CA, 0, k);
    wait_check(0, k, "single_fault");
  endtask

  task automatic test_mixed_function();
    int k;
    logic [15:0] m;
    logic [3:0]  v;
    for (int i = 0; i < 16; i++) begin
      v    = i[3:0];
      m[i] = (~v[3] & ~v[0]) | (v[2] & v[0]);
    end
    model_v[0] = m;
    sb.push_back(predict(16'hAA87, m, settle_of[0]));
    do_start(0, 16'hAA87, 0, k);
    wait_check(0, k, "mixed_function");
  endtask

  task automatic test_restart_ignored();
    int k;
    int extra = 0;
    model_v[0] = 16'h88CA;
    sb.push_back(predict(16'h88CA, 16'h88CA, settle_of[0]));
    do_start(0, 16'h88CA, 0, k);
    repeat (9) @(posedge clk);
    @(negedge clk);
    exp_v[0]   = 16'h0000;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_check(0, k, "restart_ignored");
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) extra++;
    end
    vectors++;
    if (extra != 0 || busy_v[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL restart_extra_done: got %0d extra pulses busy=%b want 0 and busy=0", extra, busy_v[0]);
    end
  endtask

  task automatic test_reset_midsweep();
    int k;
    int seen = 0;
    model_v[0] = 16'h88CA;
    do_start(0, 16'h88CA, 0, k);
    repeat (13) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (busy_v[0] !== 1'b0 || drive_v[0] !== 4'h0 || cap_v[0] !== 16'h0 || done_v[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_midsweep: got busy=%b drive=%h cap=%h done=%b want 0 0 0000 0",
               busy_v[0], drive_v[0], cap_v[0], done_v[0]);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d done pulses want 0", seen);
    end
    test_exact(0, "after_reset");
  endtask

  task automatic test_back_to_back();
    int k;
    model_v[0] = 16'h88CA;
    sb.push_back(predict(16'hAA87, 16'h88CA, settle_of[0]));
    do_start(0, 16'hAA87, 0, k);
    wait_check(0, k, "b2b_first");
    sb.push_back(predict(16'h88CA, 16'h88CA, settle_of[0]));
    do_start(0, 16'h88CA, 1, k);
    wait_check(0, k, "b2b_second");
  endtask

  initial begin
    test_reset();
    test_exact(0, "exact_s1");
    test_single_fault();
    test_mixed_function();
    test_restart_ignored();
    test_reset_midsweep();
    test_back_to_back();
    test_exact(1, "exact_s0");
    test_exact(2, "exact_s3");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: bench did not finish within 1 ms simulated");
    $fatal(1, "global timeout");
  end

endmodule
